chunked_serial_adder: RTL and testbench

Parametrised multi-cycle adder that adds two WIDTH-bit operands plus carry-in by processing CHUNK-bit slices, LSB slice first, one slice per clock. It generalises the team's 2-bit combinational full-adder slice into a width-scalable, area-lean sequential datapath with a start/done handshake and signed-overflow flag. It is intended for datapaths where a full-width carry chain is too costly and latency of WIDTH/CHUNK cycles is acceptable.

---
 rtl/chunked_serial_adder.sv | 122 ++++++++++++
 tb/tb_chunked_serial_adder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_serial_adder.sv
// rtl/chunked_serial_adder.sv - multi-cycle adder, CHUNK bits per clock, LSB slice first
// Start/done handshake; Sum/Cout/ovf update only on the completing edge.
module chunked_serial_adder #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             ovf
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int CP1    = CHUNK + 1;
   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   generate
      if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
         $error("chunked_serial_adder: WIDTH must be a positive multiple of CHUNK");
      end
   endgenerate

   logic [1:0]       state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] psum;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             a_msb;
   logic             b_msb;
   logic [WIDTH-1:0] sum_r;
   logic             cout_r;
   logic             ovf_r;

   logic [CHUNK:0]   slice;
   logic [WIDTH-1:0] a_shift;
   logic [WIDTH-1:0] b_shift;
   logic [WIDTH-1:0] psum_next;

   always_comb begin
      slice = {1'b0, a_reg[CHUNK-1:0]} + {1'b0, b_reg[CHUNK-1:0]} + CP1'(carry);
   end

   // Operands shift right so the active slice is always at bit 0; the partial sum fills from the top.
   generate
      if (NCHUNK > 1) begin : g_multi
         assign a_shift   = {{CHUNK{1'b0}}, a_reg[WIDTH-1:CHUNK]};
         assign b_shift   = {{CHUNK{1'b0}}, b_reg[WIDTH-1:CHUNK]};
         assign psum_next = {slice[CHUNK-1:0], psum[WIDTH-1:CHUNK]};
      end else begin : g_single
         assign a_shift   = '0;
         assign b_shift   = '0;
         assign psum_next = slice[CHUNK-1:0];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         a_reg  <= '0;
         b_reg  <= '0;
         psum   <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         sum_r  <= '0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  a_reg <= A;
                  b_reg <= B;
                  carry <= Cin;
                  cnt   <= '0;
                  psum  <= '0;
                  a_msb <= A[WIDTH-1];
                  b_msb <= B[WIDTH-1];
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               a_reg <= a_shift;
               b_reg <= b_shift;
               psum  <= psum_next;
               carry <= slice[CHUNK];
               cnt   <= cnt + 1'b1;
               if (cnt == LAST) begin
                  sum_r  <= psum_next;
                  cout_r <= slice[CHUNK];
                  ovf_r  <= (a_msb == b_msb) && (psum_next[WIDTH-1] != a_msb);
                  state  <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);
   assign Sum  = sum_r;
   assign Cout = cout_r;
   assign ovf  = ovf_r;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// tb/tb_chunked_serial_adder.sv - directed bench for chunked_serial_adder
// Covers WIDTH=8/CHUNK=2 handshake cases plus exhaustive 4-bit checks at CHUNK=1 and CHUNK=4.
module tb_chunked_serial_adder;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] A, B;
   logic       Cin;
   logic       busy, done, Cout, ovf;
   logic [7:0] Sum;

   logic       s4;
   logic [3:0] a4, b4;
   logic       c4;
   logic       busy41, done41, cout41, ovf41;
   logic [3:0] sum41;
   logic       busy44, done44, cout44, ovf44;
   logic [3:0] sum44;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   chunked_serial_adder #(.WIDTH(8), .CHUNK(2)) u_dut (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Cin(Cin),
      .busy(busy), .done(done), .Sum(Sum), .Cout(Cout), .ovf(ovf)
   );

   chunked_serial_adder #(.WIDTH(4), .CHUNK(1)) u_d41 (
      .clk(clk), .rst(rst), .start(s4), .A(a4), .B(b4), .Cin(c4),
      .busy(busy41), .done(done41), .Sum(sum41), .Cout(cout41), .ovf(ovf41)
   );

   chunked_serial_adder #(.WIDTH(4), .CHUNK(4)) u_d44 (
      .clk(clk), .rst(rst), .start(s4), .A(a4), .B(b4), .Cin(c4),
      .busy(busy44), .done(done44), .Sum(sum44), .Cout(cout44), .ovf(ovf44)
   );

   // Called at a negedge; start is seen by exactly one rising edge.
   task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic c);
      A = a; B = b; Cin = c; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int n0, output int lat);
      int n;
      n = n0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      lat = n;
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, n);
      end
   endtask

   task automatic test_reset;
      bit seen;
      rst = 1'b1;
      A = 8'($urandom); B = 8'($urandom); Cin = 1'($urandom); start = 1'b1;
      s4 = 1'b1; a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, Sum, Cout, ovf} !== 12'h000) begin
         errors++;
         $display("FAIL reset_held: busy/done/Sum/Cout/ovf=%h required 000", {busy, done, Sum, Cout, ovf});
      end
      start = 1'b0; s4 = 1'b0; rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, done, Sum, Cout, ovf} !== 12'h000) begin
         errors++;
         $display("FAIL reset_release: busy/done/Sum/Cout/ovf=%h required 000", {busy, done, Sum, Cout, ovf});
      end
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (done || busy || done41 || done44) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_done: activity=%b without start, required 0", seen);
      end
   endtask

   task automatic test_carry_wrap;
      bit bad;
      start_op(8'hFF, 8'h01, 1'b0);
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (busy !== 1'b1 || done !== 1'b0 || Sum !== 8'h00 || Cout !== 1'b0) bad = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (bad !== 1'b0) begin
         errors++;
         $display("FAIL run_phase: busy/done/partial-sum wrong during RUN flag=%b, required 0", bad);
      end
      checks++;
      if ({busy, done, Sum, Cout, ovf} !== {1'b0, 1'b1, 8'h00, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL carry_wrap: busy/done/Sum/Cout/ovf=%b_%b_%h_%b_%b required 0_1_00_1_0",
                  busy, done, Sum, Cout, ovf);
      end
      @(negedge clk);
      checks++;
      if ({busy, done, Sum, Cout} !== {1'b0, 1'b0, 8'h00, 1'b1}) begin
         errors++;
         $display("FAIL done_pulse_hold: busy/done/Sum/Cout=%b_%b_%h_%b required 0_0_00_1",
                  busy, done, Sum, Cout);
      end
   endtask

   task automatic test_overflow;
      int lat;
      start_op(8'h7F, 8'h01, 1'b0);
      wait_done(1, lat);
      checks++;
      if ({Sum, Cout, ovf} !== {8'h80, 1'b0, 1'b1} || lat != 5) begin
         errors++;
         $display("FAIL ovf_pos: Sum/Cout/ovf=%h_%b_%b lat=%0d required 80_0_1 lat=5", Sum, Cout, ovf, lat);
      end
      @(negedge clk);
      start_op(8'h80, 8'h80, 1'b1);
      wait_done(1, lat);
      checks++;
      if ({Sum, Cout, ovf} !== {8'h01, 1'b1, 1'b1} || lat != 5) begin
         errors++;
         $display("FAIL ovf_neg: Sum/Cout/ovf=%h_%b_%b lat=%0d required 01_1_1 lat=5", Sum, Cout, ovf, lat);
      end
   endtask

   task automatic test_back_to_back;
      int lat;
      @(negedge clk);
      start_op(8'h03, 8'h03, 1'b1);
      A = 8'hAA; B = 8'h55; Cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0; A = 8'hC3; B = 8'h11;
      wait_done(2, lat);
      checks++;
      if ({Sum, Cout, ovf} !== {8'h07, 1'b0, 1'b0} || lat != 5) begin
         errors++;
         $display("FAIL ignore_start_in_run: Sum/Cout/ovf=%h_%b_%b lat=%0d required 07_0_0 lat=5",
                  Sum, Cout, ovf, lat);
      end
      start_op(8'h0F, 8'hF1, 1'b0);
      wait_done(1, lat);
      checks++;
      if ({Sum, Cout, ovf} !== {8'h00, 1'b1, 1'b0} || lat != 5) begin
         errors++;
         $display("FAIL back_to_back: Sum/Cout/ovf=%h_%b_%b lat=%0d required 00_1_0 lat=5",
                  Sum, Cout, ovf, lat);
      end
   endtask

   task automatic test_reset_mid_run;
      int  lat;
      bit  seen;
      @(negedge clk);
      start_op(8'hFF, 8'hFF, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, Sum, Cout, ovf} !== 12'h000) begin
         errors++;
         $display("FAIL reset_async: busy/done/Sum/Cout/ovf=%h required 000", {busy, done, Sum, Cout, ovf});
      end
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (done || busy) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL reset_discard: done/busy after mid-run reset=%b, required 0", seen);
      end
      start_op(8'h12, 8'h34, 1'b0);
      wait_done(1, lat);
      checks++;
      if ({Sum, Cout, ovf} !== {8'h46, 1'b0, 1'b0} || lat != 5) begin
         errors++;
         $display("FAIL after_reset: Sum/Cout/ovf=%h_%b_%b lat=%0d required 46_0_0 lat=5",
                  Sum, Cout, ovf, lat);
      end
   endtask

   task automatic test_exhaustive_4bit;
      logic [4:0] ref_s;
      logic       ref_ovf;
      bit         seen41, seen44;
      int         lat41, lat44;
      logic [3:0] r41s, r44s;
      logic       r41c, r44c, r41o, r44o;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            for (int c = 0; c < 2; c++) begin
               @(negedge clk);
               a4 = 4'(a); b4 = 4'(b); c4 = 1'(c); s4 = 1'b1;
               ref_s   = 5'(a) + 5'(b) + 5'(c);
               ref_ovf = (a4[3] == b4[3]) && (ref_s[3] != a4[3]);
               @(negedge clk);
               s4 = 1'b0;
               seen41 = 1'b0; seen44 = 1'b0; lat41 = 0; lat44 = 0;
               r41s = '0; r44s = '0; r41c = 1'b0; r44c = 1'b0; r41o = 1'b0; r44o = 1'b0;
               for (int n = 1; n < 12; n++) begin
                  if (done41 && !seen41) begin
                     seen41 = 1'b1; lat41 = n; r41s = sum41; r41c = cout41; r41o = ovf41;
                  end
                  if (done44 && !seen44) begin
                     seen44 = 1'b1; lat44 = n; r44s = sum44; r44c = cout44; r44o = ovf44;
                  end
                  if (seen41 && seen44) break;
                  @(negedge clk);
               end
               checks++;
               if (!seen41 || {r41s, r41c, r41o} !== {ref_s[3:0], ref_s[4], ref_ovf} || lat41 != 5) begin
                  errors++;
                  $display("FAIL w4c1 a=%h b=%h cin=%0d: Sum/Cout/ovf=%h_%b_%b lat=%0d required %h_%b_%b lat=5",
                           a4, b4, c, r41s, r41c, r41o, lat41, ref_s[3:0], ref_s[4], ref_ovf);
               end
               checks++;
               if (!seen44 || {r44s, r44c, r44o} !== {ref_s[3:0], ref_s[4], ref_ovf} || lat44 != 2) begin
                  errors++;
                  $display("FAIL w4c4 a=%h b=%h cin=%0d: Sum/Cout/ovf=%h_%b_%b lat=%0d required %h_%b_%b lat=2",
                           a4, b4, c, r44s, r44c, r44o, lat44, ref_s[3:0], ref_s[4], ref_ovf);
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_carry_wrap();
      test_overflow();
      test_back_to_back();
      test_reset_mid_run();
      test_exhaustive_4bit();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
